// File: rtl/dm_port_ctrl_pkg.sv
// Shared encodings for the data-memory port controller.
// Access size codes as driven by the CPU MEM stage (3 behaves as word).
// Arbitration/burst FSM state encoding.
package dm_port_ctrl_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/dm_lane_align.sv
// Byte-lane alignment between CPU-sized accesses and a 32-bit memory word.
// Purely combinational: zero latency.
// No flow control; the caller decides whether the access is actually issued.
module dm_lane_align
  import dm_port_ctrl_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        sext_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] merged_o,
  output logic [31:0] load_o,
  output logic        misaligned_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = word_i[{off_i, 3'b000} +: 8];
  assign half_sel = word_i[{off_i[1], 4'b0000} +: 16];

  // Store merge, load extract/extend and alignment check by access size.
  always_comb begin
    merged_o     = word_i;
    load_o       = word_i;
    misaligned_o = 1'b0;
    case (size_i)
      SZ_BYTE: begin
        merged_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
        load_o = {{24{sext_i & byte_sel[7]}}, byte_sel};
      end
      SZ_HALF: begin
        misaligned_o = off_i[0];
        merged_o[{off_i[1], 4'b0000} +: 16] = wdata_i[15:0];
        load_o = {{16{sext_i & half_sel[15]}}, half_sel};
      end
      default: begin
        misaligned_o = (off_i != 2'b00);
        merged_o     = wdata_i;
        load_o       = word_i;
      end
    endcase
    // A misaligned access never returns data.
    if (misaligned_o) begin
      load_o = 32'd0;
    end
  end

endmodule

// File: rtl/dm_port_ctrl.sv
// Single-port data-memory controller shared by the CPU MEM stage and a burst device.
// CPU accesses complete in the same cycle; device read data returns one cycle after its beat.
// CPU wins each cycle unless the device has waited STARVE_LIM cycles; losers see cpu_stall / no dev_beat.
module dm_port_ctrl
  import dm_port_ctrl_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int STARVE_LIM = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [1:0]        cpu_size,
  input  logic              cpu_sext,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  output logic              cpu_err,
  input  logic              dev_req,
  input  logic              dev_we,
  input  logic [ADDR_W-1:0] dev_addr,
  input  logic [3:0]        dev_len,
  input  logic [31:0]       dev_wdata,
  output logic              dev_gnt,
  output logic              dev_beat,
  output logic              dev_rvalid,
  output logic [31:0]       dev_rdata,
  output logic              dev_done,
  output logic [ADDR_W-1:0] dm_a,
  output logic [31:0]       dm_wd,
  output logic              dm_we,
  input  logic [31:0]       dm_rd
);

  // Wide enough to hold STARVE_LIM itself (and never zero width).
  localparam int SW = $clog2(STARVE_LIM + 2);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              bwe_q, bwe_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              rvalid_q;
  logic [31:0]       rdata_q;

  logic        dev_wins;
  logic        cpu_go;
  logic        mis;
  logic [31:0] merged;
  logic [31:0] load_val;
  logic        unused_addr_bits;

  // High CPU address bits are intentionally dropped so addresses wrap.
  assign unused_addr_bits = ^cpu_addr[31:ADDR_W+2];

  dm_lane_align u_lane (
    .size_i       (cpu_size),
    .sext_i       (cpu_sext),
    .off_i        (cpu_addr[1:0]),
    .word_i       (dm_rd),
    .wdata_i      (cpu_wdata),
    .merged_o     (merged),
    .load_o       (load_val),
    .misaligned_o (mis)
  );

  // Device owns the port only in BURST, and then only if the CPU is absent or has starved it.
  assign dev_wins   = (state_q == ST_BURST) &&
                      (!cpu_req || (starve_q == SW'(STARVE_LIM)));
  assign cpu_go     = cpu_req && !dev_wins;
  assign dev_beat   = dev_wins;
  assign cpu_stall  = dev_wins && cpu_req;
  assign cpu_err    = cpu_req && mis;
  assign cpu_rdata  = load_val;
  assign dev_gnt    = (state_q == ST_IDLE) && dev_req && !reset;
  assign dev_done   = (state_q == ST_DONE);
  assign dev_rvalid = rvalid_q;
  assign dev_rdata  = rdata_q;

  // Memory port mux; a stalled CPU access never writes.
  always_comb begin
    dm_a  = cpu_addr[ADDR_W+1:2];
    dm_wd = merged;
    dm_we = cpu_go && cpu_we && !mis;
    if (dev_beat) begin
      dm_a  = ptr_q;
      dm_wd = dev_wdata;
      dm_we = bwe_q;
    end
  end

  // Burst FSM next state, pointer/count advance and starvation tracking.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    bwe_d    = bwe_q;
    starve_d = starve_q;
    case (state_q)
      ST_IDLE: begin
        if (dev_req) begin
          ptr_d   = dev_addr;
          cnt_d   = dev_len;
          bwe_d   = dev_we;
          state_d = ST_BURST;
        end
      end
      ST_BURST: begin
        if (dev_wins) begin
          ptr_d = ptr_q + ADDR_W'(1);
          cnt_d = cnt_q - 4'd1;
          if (cpu_req) begin
            starve_d = '0;
          end
          if (cnt_q == 4'd0) begin
            state_d = ST_DONE;
          end
        end else begin
          starve_d = starve_q + SW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM and burst bookkeeping registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      cnt_q    <= '0;
      bwe_q    <= 1'b0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      bwe_q    <= bwe_d;
      starve_q <= starve_d;
    end
  end

  // Capture device read beats; rvalid is a one-cycle flag per beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= dev_beat && !bwe_q;
      if (dev_beat && !bwe_q) begin
        rdata_q <= dm_rd;
      end
    end
  end

endmodule

// File: tb/tb_dm_port_ctrl.sv
// Self-checking bench for dm_port_ctrl: directed scenarios plus random traffic.
// A behavioural model (beat queue, starve count, reference memory) predicts every output each cycle.
// The bench also plays the role of the combinational-read data memory.
module tb_dm_port_ctrl;

  localparam int STARVE_LIM = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, cpu_sext;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall, cpu_err;
  logic        dev_req, dev_we;
  logic [9:0]  dev_addr;
  logic [3:0]  dev_len;
  logic [31:0] dev_wdata, dev_rdata;
  logic        dev_gnt, dev_beat, dev_rvalid, dev_done;
  logic [9:0]  dm_a;
  logic [31:0] dm_wd, dm_rd;
  logic        dm_we;

  bit [31:0] tb_mem [1024];
  bit [31:0] model_mem [1024];

  int n_chk = 0;
  int n_err = 0;

  // Behavioural model state
  int        q_addr[$];
  bit [31:0] dq[$];
  bit [31:0] pre[$];
  bit        bwe;
  bit        done_pend;
  int        starve;
  bit        exp_rv;
  bit [31:0] exp_rd;

  // Observations of the last cycle, for literal checks
  bit [31:0] o_rdata, o_devrd;
  bit        o_err, o_stall, o_gnt, o_beat, o_rvalid, o_done;

  dm_port_ctrl #(.ADDR_W(10), .STARVE_LIM(STARVE_LIM)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size), .cpu_sext(cpu_sext),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall), .cpu_err(cpu_err),
    .dev_req(dev_req), .dev_we(dev_we), .dev_addr(dev_addr), .dev_len(dev_len),
    .dev_wdata(dev_wdata), .dev_gnt(dev_gnt), .dev_beat(dev_beat),
    .dev_rvalid(dev_rvalid), .dev_rdata(dev_rdata), .dev_done(dev_done),
    .dm_a(dm_a), .dm_wd(dm_wd), .dm_we(dm_we), .dm_rd(dm_rd)
  );

  always #5 clk = ~clk;

  assign dm_rd = tb_mem[dm_a];
  always @(posedge clk) if (dm_we) tb_mem[dm_a] <= dm_wd;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input bit [31:0] act, input bit [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare DUT against the model, advance the model.
  task automatic cyc(input bit rq, input bit we, input bit [1:0] sz, input bit sx,
                     input bit [31:0] ad, input bit [31:0] wd,
                     input bit drq, input bit dwe, input int dad, input int dln);
    bit burst, idle, dturn, served, mis, exp_we, old_done;
    int nb, word, sh, exp_a;
    bit [31:0] w, mask, ld, st, exp_wd;
    cpu_req = rq; cpu_we = we; cpu_size = sz; cpu_sext = sx;
    cpu_addr = ad; cpu_wdata = wd;
    dev_req = drq; dev_we = dwe; dev_addr = 10'(dad); dev_len = 4'(dln);
    dev_wdata = (dq.size() > 0) ? dq[0] : $urandom;
    #5;
    burst  = q_addr.size() > 0;
    idle   = !burst && !done_pend;
    dturn  = burst && (!rq || starve == STARVE_LIM);
    served = rq && !dturn;
    nb     = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    mis    = (ad % nb) != 0;
    word   = int'((ad >> 2) % 1024);
    w      = model_mem[word];
    sh     = (nb == 4) ? 0 : int'((ad % 4) - ((ad % 4) % nb)) * 8;
    mask   = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
    ld     = (w >> sh) & mask;
    if (sx && nb < 4 && ld[8*nb-1]) ld = ld | ~mask;
    st     = (w & ~(mask << sh)) | ((wd & mask) << sh);
    if (dturn) begin
      exp_a = q_addr[0]; exp_we = bwe; exp_wd = dev_wdata;
    end else begin
      exp_a = word; exp_we = served && we && !mis; exp_wd = st;
    end

    chk("dev_gnt", 32'(dev_gnt), 32'(idle && drq));
    chk("dev_done", 32'(dev_done), 32'(done_pend));
    chk("dev_beat", 32'(dev_beat), 32'(dturn));
    chk("cpu_stall", 32'(cpu_stall), 32'(dturn && rq));
    chk("cpu_err", 32'(cpu_err), 32'(rq && mis));
    chk("dm_we", 32'(dm_we), 32'(exp_we));
    chk("dev_rvalid", 32'(dev_rvalid), 32'(exp_rv));
    chk("dev_rdata", dev_rdata, exp_rd);
    if (dturn || served) chk("dm_a", 32'(dm_a), 32'(exp_a));
    if (exp_we) chk("dm_wd", dm_wd, exp_wd);
    if (rq && mis) chk("cpu_rdata_mis", cpu_rdata, 32'd0);
    else if (served && !we) chk("cpu_rdata", cpu_rdata, ld);

    o_rdata = cpu_rdata; o_err = cpu_err; o_stall = cpu_stall; o_gnt = dev_gnt;
    o_beat = dev_beat; o_rvalid = dev_rvalid; o_done = dev_done; o_devrd = dev_rdata;

    old_done  = done_pend;
    done_pend = 1'b0;
    exp_rv    = dturn && !bwe;
    if (dturn && !bwe) exp_rd = model_mem[q_addr[0]];
    if (dturn) begin
      if (bwe) model_mem[q_addr[0]] = dq.pop_front();
      void'(q_addr.pop_front());
      if (q_addr.size() == 0) done_pend = 1'b1;
    end
    if (served && we && !mis) model_mem[word] = st;
    if (burst && rq) starve = dturn ? 0 : starve + 1;
    if (idle && drq && !old_done) begin
      bwe = dwe;
      for (int i = 0; i <= dln; i++) begin
        q_addr.push_back((dad + i) % 1024);
        if (dwe) dq.push_back((pre.size() > 0) ? pre.pop_front() : $urandom);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cyc();
    cyc(0, 0, 2'd2, 0, 32'd0, 32'd0, 0, 0, 0, 0);
  endtask

  bit [11:0] beat_v, done_v, stall_v, rv_v;
  bit [31:0] rd6;
  bit        done_seen;
  int        guard;
  int        nmis;

  initial begin
    reset = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_size = 2'd2; cpu_sext = 0; cpu_addr = '0; cpu_wdata = '0;
    dev_req = 1; dev_we = 0; dev_addr = '0; dev_len = '0; dev_wdata = '0;
    bwe = 0; done_pend = 0; starve = 0; exp_rv = 0; exp_rd = '0;
    #3;
    // Reset state, with a device request pending (must not be granted).
    chk("rst_gnt", 32'(dev_gnt), 32'd0);
    chk("rst_done", 32'(dev_done), 32'd0);
    chk("rst_rvalid", 32'(dev_rvalid), 32'd0);
    chk("rst_rdata", dev_rdata, 32'd0);
    chk("rst_beat", 32'(dev_beat), 32'd0);
    dev_req = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    idle_cyc();

    // Word store then byte loads.
    cyc(1, 1, 2'd2, 0, 32'h10, 32'h12345678, 0, 0, 0, 0);
    cyc(1, 0, 2'd0, 0, 32'h11, 32'h0, 0, 0, 0, 0);
    chk("lbu_0x11", o_rdata, 32'h00000056);
    cyc(1, 0, 2'd0, 1, 32'h13, 32'h0, 0, 0, 0, 0);
    chk("lb_0x13", o_rdata, 32'h00000012);

    // Half store merge and sign-extending loads.
    cyc(1, 1, 2'd2, 0, 32'h0, 32'hAABBCCDD, 0, 0, 0, 0);
    cyc(1, 1, 2'd1, 0, 32'h2, 32'hFFFF1234, 0, 0, 0, 0);
    cyc(1, 0, 2'd2, 0, 32'h0, 32'h0, 0, 0, 0, 0);
    chk("lw_0_after_sh", o_rdata, 32'h1234CCDD);
    cyc(1, 0, 2'd1, 1, 32'h2, 32'h0, 0, 0, 0, 0);
    chk("lh_0x2", o_rdata, 32'h00001234);
    cyc(1, 0, 2'd0, 1, 32'h1, 32'h0, 0, 0, 0, 0);
    chk("lb_0x1_neg", o_rdata, 32'hFFFFFFCC);

    // Misaligned word store is suppressed.
    cyc(1, 1, 2'd2, 0, 32'h6, 32'hDEADBEEF, 0, 0, 0, 0);
    chk("sw_0x6_err", 32'(o_err), 32'd1);
    cyc(1, 0, 2'd2, 0, 32'h4, 32'h0, 0, 0, 0, 0);
    chk("word1_unchanged", o_rdata, 32'h0);

    // Wrapping write burst with the CPU idle.
    pre = '{32'd1, 32'd2, 32'd3, 32'd4};
    cyc(0, 0, 2'd2, 0, 32'd0, 32'd0, 1, 1, 'h3FE, 3);
    chk("wr_burst_gnt", 32'(o_gnt), 32'd1);
    beat_v = '0; done_v = '0;
    for (int k = 1; k <= 5; k++) begin
      idle_cyc();
      beat_v[k] = o_beat; done_v[k] = o_done;
    end
    chk("wr_burst_beats", 32'(beat_v), 32'h01E);
    chk("wr_burst_done", 32'(done_v), 32'h020);
    chk("mem_3FE", tb_mem[10'h3FE], 32'd1);
    chk("mem_3FF", tb_mem[10'h3FF], 32'd2);
    chk("mem_000", tb_mem[10'h000], 32'd3);
    chk("mem_001", tb_mem[10'h001], 32'd4);

    // Read burst of 2 against a CPU that requests every cycle.
    cyc(1, 0, 2'd2, 0, 32'h20, 32'h0, 1, 0, 4, 1);
    stall_v = '0; rv_v = '0; done_v = '0; rd6 = '0;
    for (int k = 1; k <= 11; k++) begin
      cyc(1, 0, 2'd2, 0, 32'h20, 32'h0, 0, 0, 0, 0);
      stall_v[k] = o_stall; rv_v[k] = o_rvalid; done_v[k] = o_done;
      if (k == 6) rd6 = o_devrd;
    end
    chk("rd_burst_stalls", 32'(stall_v), 32'h420);
    chk("rd_burst_rvalid", 32'(rv_v), 32'h840);
    chk("rd_burst_done", 32'(done_v), 32'h800);
    chk("rd_burst_beat0", rd6, 32'h12345678);

    // Reset after the second of four write beats.
    pre = '{32'hA1, 32'hA2, 32'hA3, 32'hA4};
    cyc(0, 0, 2'd2, 0, 32'd0, 32'd0, 1, 1, 'h100, 3);
    idle_cyc();
    idle_cyc();
    reset = 1'b1;
    #1;
    chk("mid_rst_beat", 32'(dev_beat), 32'd0);
    chk("mid_rst_we", 32'(dm_we), 32'd0);
    chk("mid_rst_done", 32'(dev_done), 32'd0);
    chk("mid_rst_rvalid", 32'(dev_rvalid), 32'd0);
    q_addr.delete(); dq.delete(); pre.delete();
    done_pend = 0; starve = 0; exp_rv = 0; exp_rd = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 6; k++) begin
      idle_cyc();
      done_seen = done_seen | o_done;
    end
    chk("rst_no_done", 32'(done_seen), 32'd0);
    chk("rst_mem_100", tb_mem[10'h100], 32'hA1);
    chk("rst_mem_101", tb_mem[10'h101], 32'hA2);
    chk("rst_mem_102", tb_mem[10'h102], 32'h0);
    chk("rst_mem_103", tb_mem[10'h103], 32'h0);

    // Random mixed traffic.
    for (int k = 0; k < 4000; k++) begin
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
          $urandom_range(0, 1) == 1, $urandom & 32'hF000_007F, $urandom,
          $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
          int'($urandom_range(0, 1023)), int'($urandom_range(0, 15)));
    end

    // Drain any open burst, then compare the whole memory.
    guard = 0;
    while ((q_addr.size() > 0 || done_pend) && guard < 100) begin
      idle_cyc();
      guard++;
    end
    chk("drain", 32'(q_addr.size() > 0 || done_pend), 32'd0);
    nmis = 0;
    for (int i = 0; i < 1024; i++) if (tb_mem[i] != model_mem[i]) nmis++;
    chk("mem_compare", 32'(nmis), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/dm_port_ctrl.md
Name: dm_port_ctrl

Overview:
Controller for the single-port, word-wide data memory (combinational read, write on posedge clk).
- Shares the port between the CPU MEM stage and a secondary burst requester (loader/debug DMA).
- Converts CPU byte/half/word accesses into word accesses: read-merge-write for stores, extract/extend for loads.
- CPU has per-cycle priority; a starvation counter guarantees forward progress for the device.

Parameters:
ADDR_W, 10, word-address width of the data memory (1024 words)
STARVE_LIM, 4, consecutive device-waiting cycles after which the device wins one cycle

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
cpu_req  in  1  CPU access this cycle
cpu_we  in  1  1 = store, 0 = load
cpu_size  in  2  0 = byte, 1 = half, 2 = word (3 treated as word)
cpu_sext  in  1  sign-extend byte/half loads
cpu_addr  in  32  byte address
cpu_wdata  in  32  store data, right-aligned
cpu_rdata  out  32  load data, combinational
cpu_stall  out  1  CPU lost arbitration this cycle
cpu_err  out  1  misaligned access, combinational
dev_req  in  1  burst request
dev_we  in  1  burst direction
dev_addr  in  ADDR_W  start word address
dev_len  in  4  beats minus 1
dev_wdata  in  32  current write beat
dev_gnt  out  1  one-cycle pulse: request accepted
dev_beat  out  1  combinational: beat issued this cycle; write data consumed
dev_rvalid  out  1  registered read-beat valid
dev_rdata  out  32  registered read data
dev_done  out  1  one-cycle pulse after the last beat
dm_a  out  ADDR_W  memory word address
dm_wd  out  32  memory write data
dm_we  out  1  memory write enable
dm_rd  in  32  memory read data

Behaviour:
- Reset is asynchronous and active-high. Reset values: state IDLE; beat/starve counters 0; dev_rvalid, dev_rdata, dev_gnt, dev_done all 0.
- Reset in mid-burst aborts the burst. No further writes occur and no dev_done is issued.
- States:
  - IDLE: if dev_req, pulse dev_gnt; latch dev_we, dev_addr, dev_len into a burst pointer and a remaining count; go to BURST.
  - BURST: on each cycle the device owns the port, issue one beat, increment the pointer and decrement the count. After the final beat, go to DONE.
  - DONE: pulse dev_done for one cycle, then return to IDLE. dev_req is ignored in this state.
- Arbitration, per cycle in BURST:
  - The CPU wins when cpu_req is high, unless the starve counter equals STARVE_LIM.
  - When the device wins with cpu_req high, assert cpu_stall and clear the starve counter.
  - The starve counter increments only in cycles where the device waits because the CPU won.
  - With cpu_req low, the device always wins.
  - In IDLE and DONE, the CPU always owns the port.
- CPU access, served in a single cycle:
  - dm_a = cpu_addr[ADDR_W+1:2]. Higher address bits are ignored, so addresses wrap.
  - Load: cpu_rdata takes the selected byte or half of dm_rd. Byte lane is addr[1:0]; half lane is addr[1]. Result is zero- or sign-extended per cpu_sext.
  - Store: dm_wd = dm_rd with the addressed lane replaced by the low bits of cpu_wdata; dm_we = 1. This works because the read is combinational and the write happens at the edge.
- Misalignment: half with addr[0]=1, or word with addr[1:0]≠0.
  - Assert cpu_err; force dm_we = 0 and cpu_rdata = 0.
  - Arbitration and stall behave as for a normal access.
- Device beat:
  - dm_a = burst pointer; the pointer wraps modulo 2^ADDR_W.
  - Write beat: dm_wd = dev_wdata, dm_we = 1.
  - Read beat: dev_rdata <= dm_rd and dev_rvalid <= 1 at the next edge; dev_rvalid is otherwise 0.
- A stalled CPU access has no side effects and must be re-presented by the pipeline.
- dm_we is never asserted for both requesters in the same cycle.

Decomposition:
- Shared package: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD) and FSM state encodings.
- One sub-module, dm_lane_align: purely combinational store merge and load extract/extend, reusable by the M-stage bypass logic.

Test Plan:
- Word store 0x12345678 to byte address 0x10, then lbu at 0x11 with cpu_sext=0 → cpu_rdata=0x00000056; lb at 0x13 with cpu_sext=1 → 0x00000012.
- Word 0 holds 0xAABBCCDD; sh 0x1234 at address 0x2 → word 0 = 0x1234CCDD; lh at 0x2 with cpu_sext=1 → 0x00001234.
- sw at address 0x6 → cpu_err=1, dm_we=0, memory unchanged.
- Device write burst: addr 0x3FE, len 3, data 1..4 with CPU idle → dev_gnt, then four consecutive beats to 0x3FE, 0x3FF, 0x000, 0x001, then dev_done.
- Device read burst of 2 while cpu_req is held high → CPU wins cycles 1-4; the device gets cycle 5 with cpu_stall=1; dev_rvalid in cycle 6; the second beat follows the same pattern.
- Reset asserted after the 2nd of 4 write beats → outputs clear immediately, beats 3 and 4 are never written, no dev_done.
